// File: rtl/matrix_add_sequencer_pkg.sv
// matrix_pkg: shared widths, size codes, FSM states and size decode for the matrix-add sequencer
package matrix_pkg;
    localparam int ELEM_W    = 8;
    localparam int MAX_ELEMS = 25;
    localparam int BUS_W     = ELEM_W * MAX_ELEMS;
    localparam logic [1:0] SIZE_2X2 = 2'b00;
    localparam logic [1:0] SIZE_3X3 = 2'b01;
    localparam logic [1:0] SIZE_4X4 = 2'b10;
    localparam logic [1:0] SIZE_5X5 = 2'b11;
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, DRAIN} state_t;
    function automatic logic [4:0] elem_count(input logic [1:0] size);
        return size == SIZE_2X2 ? 5'd4 : size == SIZE_3X3 ? 5'd9 : size == SIZE_4X4 ? 5'd16 : 5'd25;
    endfunction
endpackage

// File: rtl/matrix_elem_counter.sv
// matrix_elem_counter: 5-bit element index that wraps to 0 after last_idx
module matrix_elem_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    input  logic [4:0] last_idx,
    output logic [4:0] idx,
    output logic       term
);
    assign term = idx == last_idx;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) idx <= '0;
        else idx <= clr ? 5'd0 : inc ? (term ? 5'd0 : idx + 5'd1) : idx;
endmodule

// File: rtl/matrix_add_sequencer.sv
// matrix_add_sequencer: loads A/B operands, runs the combinational matrix adder once, streams the result out
module matrix_add_sequencer
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_size,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_data,
    output logic [BUS_W-1:0]  add_a,
    output logic [BUS_W-1:0]  add_b,
    output logic [1:0]        add_size,
    input  logic [BUS_W-1:0]  add_result,
    input  logic              add_overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    state_t state, state_d;
    logic [BUS_W-1:0] a_q, b_q, res_q;
    logic [1:0] size_q;
    logic ovf_q, done_q, accept, loading, fire, term;
    logic [4:0] idx, last_idx;

    assign accept   = state == IDLE && cmd_valid;
    assign loading  = state == LOAD_A || state == LOAD_B;
    // abort outranks every handshake in the same cycle
    assign fire     = !abort && ((loading && in_valid) || (state == DRAIN && out_ready));
    assign last_idx = elem_count(size_q) - 5'd1;

    matrix_elem_counter u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accept || state == EXEC),
        .inc      (fire),
        .last_idx (last_idx),
        .idx      (idx),
        .term     (term)
    );

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = cmd_valid ? LOAD_A : IDLE;
            LOAD_A:  state_d = fire && term ? LOAD_B : LOAD_A;
            LOAD_B:  state_d = fire && term ? EXEC : LOAD_B;
            EXEC:    state_d = DRAIN;
            DRAIN:   state_d = fire && term ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
        if (abort && state != IDLE) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_d;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            size_q <= SIZE_2X2;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= state == DRAIN && fire && term;
            // zeroing all slots keeps slots beyond N inert on the adder buses
            if (accept) begin
                size_q <= cmd_size;
                a_q    <= '0;
                b_q    <= '0;
                ovf_q  <= 1'b0;
            end
            if (state == LOAD_A && fire) a_q[idx*ELEM_W +: ELEM_W] <= in_data;
            if (state == LOAD_B && fire) b_q[idx*ELEM_W +: ELEM_W] <= in_data;
            if (state == EXEC && !abort) begin
                res_q <= add_result;
                ovf_q <= add_overflow;
            end
        end

    assign cmd_ready = state == IDLE;
    assign in_ready  = loading;
    assign out_valid = state == DRAIN;
    assign out_data  = res_q[idx*ELEM_W +: ELEM_W];
    assign out_last  = out_valid && term;
    assign busy      = state != IDLE;
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_size  = size_q;
endmodule

// File: tb/tb_matrix_add_sequencer.sv
// tb_matrix_add_sequencer: directed scenario tests with a behavioural combinational matrix adder
module tb_matrix_add_sequencer;
    logic clk = 1'b0, rst_n = 1'b0;
    logic cmd_valid = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0] cmd_size = 2'b00;
    logic [7:0] in_data = 8'h00;
    logic cmd_ready, in_ready, out_valid, out_last, busy, done, overflow, add_overflow;
    logic [199:0] add_a, add_b, add_result;
    logic [1:0] add_size;
    logic [7:0] out_data, s;
    logic [7:0] va [25];
    logic [7:0] vb [25];
    int checks = 0, fails = 0, nact;

    always #5 clk = ~clk;

    matrix_add_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_size(cmd_size),
        .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .add_a(add_a), .add_b(add_b), .add_size(add_size), .add_result(add_result),
        .add_overflow(add_overflow), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done), .overflow(overflow)
    );

    function automatic int nsz(input logic [1:0] sz);
        case (sz)
            2'b00: return 4;
            2'b01: return 9;
            2'b10: return 16;
            default: return 25;
        endcase
    endfunction

    assign nact = nsz(add_size);

    // external adder: masks slots >= N, flags signed overflow on any active slot
    always_comb begin
        add_result = '0;
        add_overflow = 1'b0;
        s = 8'h00;
        for (int i = 0; i < 25; i++)
            if (i < nact) begin
                s = add_a[i*8 +: 8] + add_b[i*8 +: 8];
                add_result[i*8 +: 8] = s;
                if (add_a[i*8+7] == add_b[i*8+7] && s[7] != add_a[i*8+7]) add_overflow = 1'b1;
            end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [1:0] sz);
        cmd_valid = 1'b1;
        cmd_size = sz;
        step();
        cmd_valid = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < nsz(sz); k++) begin in_data = va[k]; step(); end
        for (int k = 0; k < nsz(sz); k++) begin in_data = vb[k]; step(); end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) step();
        checks++;
        if ({cmd_ready, busy, done, out_valid, overflow, in_ready} !== 6'b100000) begin
            fails++; $display("FAIL reset_flags got %b exp 100000", {cmd_ready, busy, done, out_valid, overflow, in_ready});
        end
        checks++;
        if ({add_size, add_a, add_b} !== '0) begin fails++; $display("FAIL reset_regs got nonzero exp 0"); end
        rst_n = 1'b1;
        step();
        checks++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    endtask

    task automatic test_2x2();
        logic [7:0] e;
        for (int i = 0; i < 4; i++) begin va[i] = 8'(i + 1); vb[i] = 8'(10 * (i + 1)); end
        out_ready = 1'b1;
        start_load(2'b00);
        checks++;
        if ({in_ready, busy, out_valid} !== 3'b010) begin fails++; $display("FAIL 2x2_exec got %b exp 010", {in_ready, busy, out_valid}); end
        step();
        for (int j = 0; j < 4; j++) begin
            e = 8'(11 * (j + 1));
            checks++;
            if ({out_valid, out_last, out_data} !== {1'b1, j == 3, e}) begin
                fails++; $display("FAIL 2x2_out%0d got v=%b l=%b d=%0d exp d=%0d", j, out_valid, out_last, out_data, e);
            end
            step();
        end
        checks++;
        if ({done, busy, out_valid, overflow} !== 4'b1000) begin fails++; $display("FAIL 2x2_done got %b exp 1000", {done, busy, out_valid, overflow}); end
        checks++;
        if (add_a[199:32] !== '0 || add_a[31:0] !== 32'h04030201) begin fails++; $display("FAIL 2x2_add_a got %h exp 04030201", add_a[31:0]); end
        step();
        checks++;
        if (done !== 1'b0) begin fails++; $display("FAIL 2x2_done_pulse got %b exp 0", done); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 25; i++) begin va[i] = 8'h00; vb[i] = 8'h00; end
        va[5] = 8'h7F;
        vb[5] = 8'h01;
        out_ready = 1'b1;
        start_load(2'b01);
        step();
        checks++;
        if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_capture got %b exp 1", overflow); end
        for (int j = 0; j < 9; j++) begin
            checks++;
            if ({out_valid, out_data} !== {1'b1, j == 5 ? 8'h80 : 8'h00}) begin
                fails++; $display("FAIL ovf_out%0d got v=%b d=%h", j, out_valid, out_data);
            end
            step();
        end
        repeat (3) step();
        checks++;
        if ({busy, overflow} !== 2'b01) begin fails++; $display("FAIL ovf_hold got %b exp 01", {busy, overflow}); end
        cmd_valid = 1'b1;
        cmd_size = 2'b00;
        step();
        cmd_valid = 1'b0;
        checks++;
        if ({busy, overflow} !== 2'b10) begin fails++; $display("FAIL ovf_clear got %b exp 10", {busy, overflow}); end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_backpressure();
        int k = 0, guard = 0, nhs = 0, ndone = 0, stall = 0;
        logic tgl = 1'b1, hs;
        logic [7:0] e;
        for (int i = 0; i < 25; i++) begin va[i] = 8'(i); vb[i] = 8'(2 * i); end
        cmd_valid = 1'b1;
        cmd_size = 2'b11;
        step();
        cmd_valid = 1'b0;
        while (k < 50 && guard < 300) begin
            in_valid = tgl;
            in_data = k < 25 ? va[k] : vb[k - 25];
            hs = in_valid && in_ready;
            step();
            if (hs) k++;
            tgl = !tgl;
            guard++;
        end
        in_valid = 1'b0;
        checks++;
        if (k !== 50) begin fails++; $display("FAIL bp_load got %0d exp 50", k); end
        guard = 0;
        while (nhs < 25 && guard < 200) begin
            out_ready = 1'b1;
            if (out_valid && nhs == 7 && stall < 3) begin
                out_ready = 1'b0;
                stall++;
                checks++;
                if ({out_valid, out_last, out_data} !== {2'b10, 8'd21}) begin fails++; $display("FAIL bp_stall got d=%0d exp 21", out_data); end
            end
            if (out_valid && out_ready) begin
                e = 8'(3 * nhs);
                checks++;
                if ({out_last, out_data} !== {nhs == 24, e}) begin fails++; $display("FAIL bp_out%0d got l=%b d=%0d exp %0d", nhs, out_last, out_data, e); end
                nhs++;
            end
            ndone += int'(done);
            step();
            guard++;
        end
        repeat (3) begin ndone += int'(done); step(); end
        checks++;
        if (nhs !== 25 || stall !== 3) begin fails++; $display("FAIL bp_handshakes got %0d/%0d exp 25/3", nhs, stall); end
        checks++;
        if (ndone !== 1) begin fails++; $display("FAIL bp_done_count got %0d exp 1", ndone); end
    endtask

    task automatic test_cmd_while_busy();
        for (int i = 0; i < 4; i++) begin va[i] = 8'(5 + i); vb[i] = 8'd1; end
        out_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_size = 2'b00;
        step();
        in_valid = 1'b1;
        cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin in_data = va[k]; step(); end
        cmd_valid = 1'b1;
        cmd_size = 2'b11;
        for (int k = 0; k < 4; k++) begin
            in_data = vb[k];
            checks++;
            if (cmd_ready !== 1'b0) begin fails++; $display("FAIL busy_cmd_ready got %b exp 0", cmd_ready); end
            step();
        end
        in_valid = 1'b0;
        step();
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (out_data !== 8'(6 + j)) begin fails++; $display("FAIL busy_out%0d got %0d exp %0d", j, out_data, 6 + j); end
            step();
        end
        checks++;
        if ({done, cmd_ready, add_size} !== 4'b1100) begin fails++; $display("FAIL busy_done got %b exp 1100", {done, cmd_ready, add_size}); end
        step();
        cmd_valid = 1'b0;
        checks++;
        if ({add_size, busy, in_ready} !== 4'b1111) begin fails++; $display("FAIL busy_accept got %b exp 1111", {add_size, busy, in_ready}); end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_abort();
        for (int i = 0; i < 16; i++) begin va[i] = 8'(100 + i); vb[i] = 8'd50; end
        cmd_valid = 1'b1;
        cmd_size = 2'b10;
        step();
        cmd_valid = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin in_data = va[k]; step(); end
        for (int k = 0; k < 2; k++) begin in_data = vb[k]; step(); end
        abort = 1'b1;
        in_data = vb[2];
        step();
        abort = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({busy, done, out_valid, cmd_ready} !== 4'b0001) begin fails++; $display("FAIL abort_idle got %b exp 0001", {busy, done, out_valid, cmd_ready}); end
        checks++;
        if (add_b[23:16] !== 8'h00) begin fails++; $display("FAIL abort_priority got %h exp 00", add_b[23:16]); end
        step();
        checks++;
        if ({done, out_valid} !== 2'b00) begin fails++; $display("FAIL abort_no_done got %b exp 00", {done, out_valid}); end
        for (int i = 0; i < 4; i++) begin va[i] = 8'(3 + i); vb[i] = 8'(7 + i); end
        out_ready = 1'b1;
        start_load(2'b00);
        checks++;
        if (add_a[199:32] !== '0 || add_b[199:32] !== '0) begin fails++; $display("FAIL abort_slots_cleared got nonzero exp 0"); end
        step();
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (out_data !== 8'(10 + 2 * j)) begin fails++; $display("FAIL abort_out%0d got %0d exp %0d", j, out_data, 10 + 2 * j); end
            step();
        end
        checks++;
        if (done !== 1'b1) begin fails++; $display("FAIL abort_next_done got %b exp 1", done); end
        step();
    endtask

    task automatic test_reset_mid_drain();
        int sawdone = 0;
        for (int i = 0; i < 25; i++) begin va[i] = 8'(i); vb[i] = 8'h00; end
        vb[24] = 8'h70;
        out_ready = 1'b1;
        start_load(2'b11);
        step();
        repeat (3) step();
        checks++;
        if ({out_valid, overflow, out_data} !== {2'b11, 8'd3}) begin fails++; $display("FAIL rst_pre got v=%b o=%b d=%0d exp 1 1 3", out_valid, overflow, out_data); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, overflow, done, in_ready} !== 5'b00000) begin fails++; $display("FAIL rst_async got %b exp 00000", {out_valid, busy, overflow, done, in_ready}); end
        step();
        rst_n = 1'b1;
        checks++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
        repeat (4) begin sawdone += int'(done); step(); end
        checks++;
        if (sawdone !== 0) begin fails++; $display("FAIL rst_no_done got %0d exp 0", sawdone); end
    endtask

    initial begin
        test_reset();
        test_2x2();
        test_overflow();
        test_backpressure();
        test_cmd_while_busy();
        test_abort();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/matrix_add_sequencer.md
Name: matrix_add_sequencer

Overview:
- Sequences one matrix-add operation on the coprocessor's combinational 25-element, 8-bit matrix adder.
- Accepts a command carrying the matrix size, then loads matrix A and matrix B element-by-element over an 8-bit valid/ready stream.
- Drives the adder's packed operand buses and captures the result and overflow in one cycle.
- Streams the active result elements out over a valid/ready stream, with a last marker and a done pulse.

Parameters:
- ELEM_W, 8, element width in bits.
- MAX_ELEMS, 25, element slots on the adder buses; bus width = ELEM_W*MAX_ELEMS (200).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_size  in  2  matrix size: 00=2x2, 01=3x3, 10=4x4, 11=5x5.
- abort  in  1  synchronous cancel; returns to IDLE.
- in_valid  in  1  operand element present.
- in_ready  out  1  high in LOAD_A and LOAD_B.
- in_data  in  ELEM_W  operand element, row-major, A first then B.
- add_a  out  ELEM_W*MAX_ELEMS  operand A to the adder; element i at [i*8+:8].
- add_b  out  ELEM_W*MAX_ELEMS  operand B to the adder.
- add_size  out  2  latched cmd_size to the adder.
- add_result  in  ELEM_W*MAX_ELEMS  adder sum bus.
- add_overflow  in  1  adder overflow flag.
- out_valid  out  1  result element present (DRAIN state).
- out_ready  in  1  downstream accepts.
- out_data  out  ELEM_W  result element idx.
- out_last  out  1  out_valid and idx==N-1.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the last result handshake.
- overflow  out  1  captured overflow; held until the next command is accepted.

Behaviour:
- N = 4/9/16/25 for cmd_size 00/01/10/11, decoded from the latched size register.
- Reset (rst_n low, async): state=IDLE; idx=0; A, B and result registers=0; size=00; done=0; overflow=0; out_valid=0; in_ready=0; cmd_ready=1 once released.
- IDLE: on cmd_valid&cmd_ready:
  - latch size;
  - clear all A and B slots to 0, so inactive slots are zero;
  - clear overflow; idx=0; go to LOAD_A.
- LOAD_A:
  - each in_valid&in_ready writes in_data into A slot idx;
  - if idx==N-1: idx=0 and go to LOAD_B; else idx++.
  - in_valid low means stall with no change.
- LOAD_B: same as LOAD_A but writes B; the last element goes to EXEC.
- EXEC (exactly 1 cycle, in_ready=0):
  - register add_result into the result register and add_overflow into overflow;
  - idx=0; go to DRAIN.
  - The adder is combinational, so the operands are stable for the whole EXEC cycle.
- DRAIN:
  - out_valid=1 and out_data=result[idx*8+:8] every cycle in this state.
  - out_data and out_last must hold stable while out_valid&!out_ready.
  - on handshake with idx<N-1: idx++.
  - on handshake with idx==N-1: go to IDLE, with done=1 in the next cycle (the first IDLE cycle).
- done is registered and lasts exactly one cycle.
- cmd_valid outside IDLE is ignored and not queued. A command is accepted in the same cycle that done is high.
- Latency with no stalls:
  - command accepted in cycle 0; first in_ready in cycle 1;
  - EXEC in cycle 2N+1; out_valid in cycles 2N+2 .. 3N+1; done in cycle 3N+2.
- abort:
  - sampled in any non-IDLE state and takes priority over all handshakes that cycle;
  - next state is IDLE; no done pulse; no out_valid in the following cycle;
  - registers keep their contents, and overflow keeps its last value.
  - In IDLE, abort has no effect.
- Overflow policy: set only from add_overflow in EXEC. The adder already masks elements >= N; this block does not re-check them.
- Wrap-around: idx never exceeds N-1. Its width is 5 bits.
- Asynchronous reset mid-operation discards everything: outputs return to their reset values immediately, with no done pulse.

Decomposition:
- Shared package, matrix_pkg:
  - ELEM_W, MAX_ELEMS, size encodings SIZE_2X2 .. SIZE_5X5;
  - a function mapping size to N;
  - state enum {IDLE, LOAD_A, LOAD_B, EXEC, DRAIN}.
- Natural sub-module: matrix_elem_counter. It is a 5-bit index counter with clear, increment, and terminal-flag (idx==N-1) outputs, and is reused for the load and drain phases. Everything else stays in one FSM module.

Test Plan:
- 2x2, no stalls:
  - stimulus: A=1,2,3,4; B=10,20,30,40; out_ready=1.
  - response: out_data 11,22,33,44 in cycles 10-13; out_last only on 44; done in cycle 14; overflow=0; add_a slots 4-24 = 0.
- 3x3 signed overflow:
  - stimulus: A[5]=0x7F, B[5]=0x01, all other elements 0.
  - response: sixth output 0x80; overflow=1, held in IDLE until the next command is accepted, then cleared to 0.
- 5x5 with backpressure:
  - stimulus: A=i, B=2i; in_valid toggling every other cycle; out_ready low 3 cycles at idx 7.
  - response: outputs 3i for i=0..24; out_data stable at 21 while stalled; exactly 25 handshakes; one done pulse.
- Command while busy:
  - stimulus: cmd_valid with size 11 held high during LOAD_B of a 2x2 operation.
  - response: cmd_ready=0 and the 2x2 completes unchanged. The new command is accepted in the done cycle, and add_size becomes 11 in the following cycle.
- Abort:
  - stimulus: abort in LOAD_B at idx 2 of a 4x4 operation.
  - response: IDLE the next cycle, done=0, no out_valid. A following 2x2 operation with zeroed slots produces correct sums.
- Reset mid-DRAIN:
  - stimulus: rst_n low for 1 cycle at idx 3 of a 5x5 drain.
  - response: out_valid, busy and overflow go to 0 asynchronously, cmd_ready=1 after release, and no done pulse.
